button_event: RTL and testbench
===============================

# button_event

Converts clean, debounced button levels into single-cycle user-interface events: press, release, long-press (hold) and auto-repeat. Sits directly downstream of the debouncer on each board button/switch bus, so control logic (menus, counters, mode selects) consumes one-cycle strobes instead of levels. One independent event machine per input bit.

## Interface

- `DATA_WIDTH`, 1: number of independent button lanes.
- `HOLD_COUNT`, 32'd50_000_000: cycles from press to hold event (500 ms at 100 MHz). Legal range is 2 to 2^32-1.
- `REPEAT_COUNT`, 32'd10_000_000: cycles between auto-repeat events (100 ms). A value of 0 disables repeat; otherwise the legal minimum is 2.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `btn_in` input DATA_WIDTH: debounced button levels; 1 = pressed.
- `press_pulse` output DATA_WIDTH: one-cycle strobe on press.
- `release_pulse` output DATA_WIDTH: one-cycle strobe on release.
- `hold_pulse` output DATA_WIDTH: one-cycle strobe after the button has been held HOLD_COUNT cycles.
- `repeat_pulse` output DATA_WIDTH: one-cycle strobe every REPEAT_COUNT cycles after the hold event.
- `btn_held` output DATA_WIDTH: level; 1 from the hold event until release.

## Operation

- Each lane registers `btn_in` once into `btn_q`. All FSM decisions use `btn_q`. No further synchronisation is done; the input is already debounced and in the `clk` domain.
- Each lane has states IDLE, PRESSED and REPEATING, plus a 32-bit counter `cnt`.
- **IDLE**: if `btn_q`=1, set `press_pulse` next cycle, set `cnt`=0 and go to PRESSED.
- **PRESSED**:
  - If `btn_q`=0, set `release_pulse` and go to IDLE.
  - Else if `cnt`==HOLD_COUNT-1, set `hold_pulse`, set `cnt`=0 and go to REPEATING.
  - Else increment `cnt`.
- **REPEATING**:
  - If `btn_q`=0, set `release_pulse` and go to IDLE.
  - Else if REPEAT_COUNT≠0 and `cnt`==REPEAT_COUNT-1, set `repeat_pulse` and set `cnt`=0.
  - Else, if REPEAT_COUNT≠0, increment `cnt`. When REPEAT_COUNT=0, `cnt` holds.
- `btn_held` is 1 exactly when the state is REPEATING, and is registered.
- Release has priority: if release coincides with a terminal count, only `release_pulse` fires.
- Lanes are fully independent. Simultaneous events on different lanes all fire in the same cycle.
- The counter never wraps, because it is cleared at each terminal count.

## Timing

- All outputs are registered. Reset value is 0 for every output, `btn_q`, `cnt`, and state (IDLE).
- `rst` asserted mid-operation clears everything on the next edge, and no pulse is emitted on that edge.
- If `btn_in` is held high through reset, `press_pulse` fires in the 2nd cycle after `rst` deasserts.
- Let cycle C be the first cycle with `btn_q`=1; `press_pulse` is high in cycle P = C+1.
- `hold_pulse` is high in cycle P+HOLD_COUNT. `btn_held` rises in the same cycle.
- `repeat_pulse` is high in cycles P+HOLD_COUNT+n·REPEAT_COUNT, for n ≥ 1.
- Release latency: if the first cycle with `btn_q`=0 is R, then `release_pulse` is high in R+1 and `btn_held` falls in R+1.
- Every pulse is exactly one cycle wide. There is no back-pressure or handshake; consumers must sample every cycle.
- A one-cycle press (1 then 0 on `btn_in`) produces `press_pulse` followed by `release_pulse` in consecutive cycles.

## Structure

- Package `button_event_pkg` holds:
  - the state enum typedef `btn_state_t` (IDLE, PRESSED, REPEATING), 2 bits;
  - the counter width constant `CNT_W` = 32.
- Sub-module `button_event_lane` holds one lane: input register, FSM and counter, with HOLD_COUNT and REPEAT_COUNT passed through.
- The top level instantiates DATA_WIDTH lanes with a generate loop and concatenates their outputs.

## Test plan

All scenarios use HOLD_COUNT=8, REPEAT_COUNT=4 unless stated otherwise.

1. Short press: `btn_in`=1 for 3 cycles, then 0 → `press_pulse` at P, `release_pulse` at P+3, no hold, `btn_held` stays 0.
2. Long hold: `btn_in`=1 for 20 cycles → `press_pulse` at P, `hold_pulse` at P+8, `repeat_pulse` at P+12 and P+16, `btn_held` high from P+8. After release, `release_pulse` fires once and `btn_held` falls in the same cycle.
3. Release exactly when `cnt`==7 in PRESSED → `release_pulse` only, no `hold_pulse`, FSM returns to IDLE.
4. `rst` pulsed for 1 cycle at P+10 with `btn_in` still 1:
   - all outputs are 0 the cycle after `rst`;
   - `press_pulse` fires again 2 cycles after deassertion;
   - `hold_pulse` fires 8 cycles after that `press_pulse`.
5. DATA_WIDTH=2, REPEAT_COUNT=0:
   - lane 0 held 30 cycles and lane 1 pressed for 2 cycles, both starting in the same cycle;
   - both `press_pulse` bits rise in the same cycle;
   - lane 1 releases independently;
   - lane 0 gets `hold_pulse` at P+8 and no `repeat_pulse`.
6. One-cycle `btn_in` glitch → `press_pulse` at P and `release_pulse` at P+1, each exactly one cycle wide.

Source files
------------

// File: rtl/button_event_pkg.sv
// button_event_pkg
//   Shared definitions for the button event block.
//   - btn_state_t : per-lane event FSM state (IDLE, PRESSED, REPEATING)
//   - CNT_W       : width of the per-lane hold/repeat counter
package button_event_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } btn_state_t;

endpackage : button_event_pkg

// File: rtl/button_event_lane.sv
// button_event_lane
//   One button lane: registers the debounced level once, then runs the
//   press / hold / auto-repeat FSM on the registered copy. Every output is a
//   flop, so consumers see clean one-cycle strobes.
//
// Ports
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   btn_in        : debounced button level, 1 = pressed
//   press_pulse   : one-cycle strobe on press
//   release_pulse : one-cycle strobe on release
//   hold_pulse    : one-cycle strobe after HOLD_COUNT cycles held
//   repeat_pulse  : one-cycle strobe every REPEAT_COUNT cycles after hold
//   btn_held      : level, high while in the REPEATING state
module button_event_lane
  import button_event_pkg::*;
#(
  parameter logic [CNT_W-1:0] HOLD_COUNT   = 32'd50_000_000,
  parameter logic [CNT_W-1:0] REPEAT_COUNT = 32'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse,
  output logic btn_held
);

  // Terminal counts. The counter restarts from 0 on entry to PRESSED and on
  // every hold/repeat event, so it reaches at most the larger terminal value
  // and never wraps.
  localparam logic [CNT_W-1:0] HOLD_LAST   = HOLD_COUNT - 32'd1;
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_COUNT - 32'd1;
  localparam bit               REPEAT_EN   = (REPEAT_COUNT != 32'd0);

  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  btn_state_t       state;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q         <= 1'b0;
      cnt           <= '0;
      state         <= IDLE;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      btn_held      <= 1'b0;
    end else begin
      btn_q <= btn_in;

      // Strobes default low; each branch raises at most one for a cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        IDLE: begin
          btn_held <= 1'b0;
          if (btn_q) begin
            press_pulse <= 1'b1;
            cnt         <= '0;
            state       <= PRESSED;
          end
        end

        PRESSED: begin
          // Release is checked first so it wins over a coincident hold.
          if (!btn_q) begin
            release_pulse <= 1'b1;
            state         <= IDLE;
          end else if (cnt == HOLD_LAST) begin
            hold_pulse <= 1'b1;
            btn_held   <= 1'b1;
            cnt        <= '0;
            state      <= REPEATING;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        REPEATING: begin
          if (!btn_q) begin
            release_pulse <= 1'b1;
            btn_held      <= 1'b0;
            state         <= IDLE;
          end else if (REPEAT_EN) begin
            if (cnt == REPEAT_LAST) begin
              repeat_pulse <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          // With repeat disabled the counter simply holds.
        end

        default: begin
          // Unreachable encoding: recover quietly to IDLE.
          btn_held <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule : button_event_lane

// File: rtl/button_event.sv
// button_event
//   Turns debounced button levels into one-cycle UI events (press, release,
//   long-press hold, auto-repeat). One fully independent lane per input bit.
//
// Ports
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   btn_in        : [DATA_WIDTH] debounced button levels, 1 = pressed
//   press_pulse   : [DATA_WIDTH] one-cycle press strobes
//   release_pulse : [DATA_WIDTH] one-cycle release strobes
//   hold_pulse    : [DATA_WIDTH] one-cycle hold strobes
//   repeat_pulse  : [DATA_WIDTH] one-cycle auto-repeat strobes
//   btn_held      : [DATA_WIDTH] high from hold event until release
module button_event
  import button_event_pkg::*;
#(
  parameter int               DATA_WIDTH   = 1,
  parameter logic [CNT_W-1:0] HOLD_COUNT   = 32'd50_000_000,
  parameter logic [CNT_W-1:0] REPEAT_COUNT = 32'd10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] btn_in,
  output logic [DATA_WIDTH-1:0] press_pulse,
  output logic [DATA_WIDTH-1:0] release_pulse,
  output logic [DATA_WIDTH-1:0] hold_pulse,
  output logic [DATA_WIDTH-1:0] repeat_pulse,
  output logic [DATA_WIDTH-1:0] btn_held
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : lane_g
      button_event_lane #(
        .HOLD_COUNT   (HOLD_COUNT),
        .REPEAT_COUNT (REPEAT_COUNT)
      ) u_lane (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in[gi]),
        .press_pulse   (press_pulse[gi]),
        .release_pulse (release_pulse[gi]),
        .hold_pulse    (hold_pulse[gi]),
        .repeat_pulse  (repeat_pulse[gi]),
        .btn_held      (btn_held[gi])
      );
    end
  endgenerate

endmodule : button_event

// File: tb/tb_button_event.sv
// tb_button_event
//   Directed bench for button_event. Two instances: dut_a (1 lane, hold 8,
//   repeat 4) and dut_b (2 lanes, hold 8, repeat disabled). Each scenario is
//   a set of 32-bit masks: bit k of an input mask is driven in cycle k, bit k
//   of an expected mask is the output value sampled just after edge k.
module tb_button_event;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [0:0] btn_a;
  logic [1:0] btn_b;
  logic [0:0] press_a, release_a, hold_a, repeat_a, held_a;
  logic [1:0] press_b, release_b, hold_b, repeat_b, held_b;

  button_event #(
    .DATA_WIDTH(1), .HOLD_COUNT(32'd8), .REPEAT_COUNT(32'd4)
  ) dut_a (
    .clk(clk), .rst(rst_a), .btn_in(btn_a),
    .press_pulse(press_a), .release_pulse(release_a), .hold_pulse(hold_a),
    .repeat_pulse(repeat_a), .btn_held(held_a)
  );

  button_event #(
    .DATA_WIDTH(2), .HOLD_COUNT(32'd8), .REPEAT_COUNT(32'd0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .btn_in(btn_b),
    .press_pulse(press_b), .release_pulse(release_b), .hold_pulse(hold_b),
    .repeat_pulse(repeat_b), .btn_held(held_b)
  );

  int checks = 0;
  int errors = 0;

  // Output vectors are {press, release, hold, repeat, held}.
  task automatic check_val(input string tag, input logic [4:0] got,
                           input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (press,release,hold,repeat,held)",
               tag, got, exp);
    end
  endtask

  function automatic logic [4:0] pick(input int k, input logic [31:0] p,
      input logic [31:0] r, input logic [31:0] h, input logic [31:0] rp,
      input logic [31:0] hd);
    return {p[k], r[k], h[k], rp[k], hd[k]};
  endfunction

  // sel=0 drives dut_a (lane-1 masks ignored), sel=1 drives dut_b.
  task automatic run(input string tag, input bit sel, input int n,
      input logic [31:0] rst_m, input logic [31:0] b0_m, input logic [31:0] b1_m,
      input logic [31:0] p0, input logic [31:0] r0, input logic [31:0] h0,
      input logic [31:0] rp0, input logic [31:0] hd0,
      input logic [31:0] p1, input logic [31:0] r1, input logic [31:0] h1,
      input logic [31:0] rp1, input logic [31:0] hd1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!sel) begin
        rst_a    = rst_m[k];
        btn_a[0] = b0_m[k];
      end else begin
        rst_b = rst_m[k];
        btn_b = {b1_m[k], b0_m[k]};
      end
      @(posedge clk);
      #1;
      if (!sel) begin
        check_val($sformatf("%s c%0d", tag, k),
                  {press_a[0], release_a[0], hold_a[0], repeat_a[0], held_a[0]},
                  pick(k, p0, r0, h0, rp0, hd0));
      end else begin
        check_val($sformatf("%s c%0d lane0", tag, k),
                  {press_b[0], release_b[0], hold_b[0], repeat_b[0], held_b[0]},
                  pick(k, p0, r0, h0, rp0, hd0));
        check_val($sformatf("%s c%0d lane1", tag, k),
                  {press_b[1], release_b[1], hold_b[1], repeat_b[1], held_b[1]},
                  pick(k, p1, r1, h1, rp1, hd1));
      end
    end
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    btn_a = '0;
    btn_b = '0;
    $display("scenario %s done, checks=%0d errors=%0d", tag, checks, errors);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    btn_a = '0;
    btn_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset dut_a", {press_a[0], release_a[0], hold_a[0], repeat_a[0], held_a[0]}, 5'b0);
    check_val("reset dut_b lane0", {press_b[0], release_b[0], hold_b[0], repeat_b[0], held_b[0]}, 5'b0);
    check_val("reset dut_b lane1", {press_b[1], release_b[1], hold_b[1], repeat_b[1], held_b[1]}, 5'b0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);

    // 1. Short press, 3 cycles: press at 1, release at 4, nothing else.
    run("short", 1'b0, 8, 32'h0, 32'h0000_0007, 32'h0,
        32'h0000_0002, 32'h0000_0010, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // 2. Long hold, 20 cycles: hold at 9, repeats at 13 and 17; the repeat
    //    due at 21 coincides with release and is suppressed.
    run("long", 1'b0, 23, 32'h0, 32'h000F_FFFF, 32'h0,
        32'h0000_0002, 32'h0020_0000, 32'h0000_0200, 32'h0002_2000, 32'h001F_FE00,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // 3. Release seen exactly when cnt==7: release at 9, no hold.
    run("rel_at_term", 1'b0, 12, 32'h0, 32'h0000_00FF, 32'h0,
        32'h0000_0002, 32'h0000_0200, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // 4. Reset during cycle P+10 with button held: all zero at 12 (the
    //    repeat due at 13 never fires), press again at 14, hold at 22.
    run("mid_reset", 1'b0, 26, 32'h0000_1000, 32'h00FF_FFFF, 32'h0,
        32'h0000_4002, 32'h0200_0000, 32'h0040_0200, 32'h0, 32'h01C0_0E00,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // 5. Two lanes, repeat disabled: lane0 held 30 cycles, lane1 2 cycles.
    run("two_lane", 1'b1, 32, 32'h0, 32'h3FFF_FFFF, 32'h0000_0003,
        32'h0000_0002, 32'h8000_0000, 32'h0000_0200, 32'h0, 32'h7FFF_FE00,
        32'h0000_0002, 32'h0000_0008, 32'h0, 32'h0, 32'h0);

    // 6. One-cycle glitch: press at 1, release at 2.
    run("glitch", 1'b0, 5, 32'h0, 32'h0000_0001, 32'h0,
        32'h0000_0002, 32'h0000_0004, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_button_event
